// File: rtl/sram_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_bist_pkg
// Description : Shared types and constants for the SRAM BIST responder.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_bist_pkg;

    // Interface widths of the board SRAM that the responder stands in for
    localparam int SRAM_ADDR_W  = 18;
    localparam int SRAM_DATA_W  = 16;

    // Cycles from address presentation to valid read data
    localparam int READ_LATENCY = 2;

    // Responder sequencing: sweep the array, then service accesses forever
    typedef enum logic [0:0] {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } resp_state_t;

endpackage : sram_bist_pkg
`default_nettype wire

// File: rtl/sram_bist_array.sv
`default_nettype none
// ============================================================================
// Module      : sram_bist_array
// Description : Single-port synchronous RAM, 2^ADDR_W words, registered read.
//               Written so it maps onto a block RAM with an output register.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_bist_array #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    // Storage write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Registered read; holds the last result until the next read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : sram_bist_array
`default_nettype wire

// File: rtl/sram_bist_responder.sv
`default_nettype none
// ============================================================================
// Module      : sram_bist_responder
// Description : Memory-side responder for the BIST address/data/we_n bus.
//               Sweeps the on-chip array to INIT_VALUE, then services
//               accesses with 2-cycle read latency, a stuck-at fault on one
//               full address, and saturating access statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_bist_responder
    import sram_bist_pkg::*;
#(
    parameter int               ADDR_W     = 12,
    parameter logic [15:0]      INIT_VALUE = 16'h0000,
    parameter int               CNT_W      = 20
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [SRAM_ADDR_W-1:0] Address,
    input  logic [SRAM_DATA_W-1:0] Write_data,
    input  logic                   We_n,
    output logic [SRAM_DATA_W-1:0] Read_data,
    output logic                   Ready,
    input  logic                   Fault_enable,
    input  logic [SRAM_ADDR_W-1:0] Fault_address,
    input  logic [3:0]             Fault_bit,
    input  logic                   Fault_value,
    input  logic                   Clear_stats,
    output logic [CNT_W-1:0]       Write_count,
    output logic [CNT_W-1:0]       Read_count,
    output logic [CNT_W-1:0]       Dropped_count
);

    localparam logic [ADDR_W-1:0] c_last_ptr = '1;
    localparam logic [CNT_W-1:0]  c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

    resp_state_t             r_state;
    resp_state_t             w_state_nxt;
    logic [ADDR_W-1:0]       r_init_ptr;

    // Stage 1: captured access plus the fault decision for it
    logic                    r_s1_valid;
    logic                    r_s1_we_n;
    logic [ADDR_W-1:0]       r_s1_index;
    logic [SRAM_DATA_W-1:0]  r_s1_wdata;
    logic                    r_s1_fault_hit;
    logic [3:0]              r_s1_fault_bit;
    logic                    r_s1_fault_val;

    // Stage 2: fault decision travelling alongside the array read register
    logic                    r_s2_fault_hit;
    logic [3:0]              r_s2_fault_bit;
    logic                    r_s2_fault_val;

    logic                    w_mem_we;
    logic                    w_mem_re;
    logic [ADDR_W-1:0]       w_mem_addr;
    logic [SRAM_DATA_W-1:0]  w_mem_wdata;
    logic [SRAM_DATA_W-1:0]  w_mem_rdata;

    logic [CNT_W-1:0]        r_wr_cnt;
    logic [CNT_W-1:0]        r_rd_cnt;
    logic [CNT_W-1:0]        r_drop_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + c_cnt_one;
    endfunction

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and array port steering: init sweep owns the port in S_INIT,
    // stage 1 owns it in S_READY. A write commits one edge before a following
    // read samples the array, so write-then-read of one index sees new data.
    always_comb begin
        w_state_nxt = r_state;
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;
        w_mem_addr  = r_s1_index;
        w_mem_wdata = r_s1_wdata;
        case (r_state)
            S_INIT: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_init_ptr;
                w_mem_wdata = INIT_VALUE;
                if (r_init_ptr == c_last_ptr) begin
                    w_state_nxt = S_READY;
                end
            end
            S_READY: begin
                w_mem_we = r_s1_valid & ~r_s1_we_n;
                w_mem_re = r_s1_valid &  r_s1_we_n;
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    // Init sweep pointer
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_init_ptr <= '0;
        end else if (r_state == S_INIT) begin
            r_init_ptr <= r_init_ptr + 1'b1;
        end
    end

    // Stage 1 capture; the full 18-bit fault compare keeps aliases clean
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_s1_valid     <= 1'b0;
            r_s1_we_n      <= 1'b1;
            r_s1_index     <= '0;
            r_s1_wdata     <= '0;
            r_s1_fault_hit <= 1'b0;
            r_s1_fault_bit <= '0;
            r_s1_fault_val <= 1'b0;
        end else begin
            r_s1_valid <= (r_state == S_READY);
            if (r_state == S_READY) begin
                r_s1_we_n      <= We_n;
                r_s1_index     <= Address[ADDR_W-1:0];
                r_s1_wdata     <= Write_data;
                r_s1_fault_hit <= Fault_enable && (Address == Fault_address);
                r_s1_fault_bit <= Fault_bit;
                r_s1_fault_val <= Fault_value;
            end
        end
    end

    // Stage 2 fault info, updated only with a read so Read_data holds
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_s2_fault_hit <= 1'b0;
            r_s2_fault_bit <= '0;
            r_s2_fault_val <= 1'b0;
        end else if (w_mem_re) begin
            r_s2_fault_hit <= r_s1_fault_hit;
            r_s2_fault_bit <= r_s1_fault_bit;
            r_s2_fault_val <= r_s1_fault_val;
        end
    end

    sram_bist_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (SRAM_DATA_W)
    ) u_array (
        .clk     (Clock),
        .rst     (Reset),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (w_mem_addr),
        .i_wdata (w_mem_wdata),
        .o_rdata (w_mem_rdata)
    );

    // Output with the stuck-at bit forced on the faulty word
    always_comb begin
        Read_data = w_mem_rdata;
        if (r_s2_fault_hit) begin
            Read_data[r_s2_fault_bit] = r_s2_fault_val;
        end
    end

    assign Ready = (r_state == S_READY);

    // Saturating statistics; clear wins over a same-cycle increment
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_drop_cnt <= '0;
        end else if (Clear_stats) begin
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_drop_cnt <= '0;
        end else if (r_state == S_READY) begin
            if (!We_n) begin
                r_wr_cnt <= sat_inc(r_wr_cnt);
            end else begin
                r_rd_cnt <= sat_inc(r_rd_cnt);
            end
        end else if (!We_n) begin
            r_drop_cnt <= sat_inc(r_drop_cnt);
        end
    end

    assign Write_count   = r_wr_cnt;
    assign Read_count    = r_rd_cnt;
    assign Dropped_count = r_drop_cnt;

endmodule : sram_bist_responder
`default_nettype wire

// File: tb/tb_sram_bist_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_bist_responder
// Description : Directed self-checking bench for sram_bist_responder.
//               Inputs change 1 time unit after a rising edge; outputs are
//               observed at that same point, i.e. during the new cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_bist_responder;

    localparam int CNT_W = 4;

    logic             Clock;
    logic             Reset;
    logic [17:0]      Address;
    logic [15:0]      Write_data;
    logic             We_n;
    logic [15:0]      Read_data;
    logic             Ready;
    logic             Fault_enable;
    logic [17:0]      Fault_address;
    logic [3:0]       Fault_bit;
    logic             Fault_value;
    logic             Clear_stats;
    logic [CNT_W-1:0] Write_count;
    logic [CNT_W-1:0] Read_count;
    logic [CNT_W-1:0] Dropped_count;

    int total;
    int bad;

    sram_bist_responder #(
        .ADDR_W     (12),
        .INIT_VALUE (16'h0000),
        .CNT_W      (CNT_W)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .Address       (Address),
        .Write_data    (Write_data),
        .We_n          (We_n),
        .Read_data     (Read_data),
        .Ready         (Ready),
        .Fault_enable  (Fault_enable),
        .Fault_address (Fault_address),
        .Fault_bit     (Fault_bit),
        .Fault_value   (Fault_value),
        .Clear_stats   (Clear_stats),
        .Write_count   (Write_count),
        .Read_count    (Read_count),
        .Dropped_count (Dropped_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic we_n, input logic [17:0] a, input logic [15:0] d);
        We_n       = we_n;
        Address    = a;
        Write_data = d;
    endtask

    task automatic idle();
        drive(1'b1, 18'h00000, 16'h0000);
    endtask

    // Write in cycle t, read in t+1; returns positioned in cycle t+3
    task automatic wr_then_rd(input logic [17:0] wa, input logic [15:0] wd, input logic [17:0] ra);
        drive(1'b0, wa, wd);
        tick();
        drive(1'b1, ra, 16'h0000);
        tick();
        idle();
        tick();
    endtask

    // Read in cycle r; returns positioned in cycle r+2
    task automatic rd(input logic [17:0] ra);
        drive(1'b1, ra, 16'h0000);
        tick();
        idle();
        tick();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (Ready !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        repeat (2) tick();
        total++; if (Ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", Ready); end
        total++; if (Read_data !== 16'h0000) begin bad++; $display("FAIL rst_rdata: got %h want 0000", Read_data); end
        total++; if (Write_count !== 4'd0 || Read_count !== 4'd0 || Dropped_count !== 4'd0) begin
            bad++; $display("FAIL rst_counts: got %0d/%0d/%0d want 0/0/0", Write_count, Read_count, Dropped_count); end
        Reset = 1'b0;
        wait_ready(n);
        total++; if (n !== 4096) begin bad++; $display("FAIL init_cycles: got %0d want 4096", n); end
        total++; if (Dropped_count !== 4'd0 || Read_count !== 4'd0) begin
            bad++; $display("FAIL init_counts: got drop=%0d rd=%0d want 0/0", Dropped_count, Read_count); end
        rd(18'h00123);
        total++; if (Read_data !== 16'h0000) begin bad++; $display("FAIL first_read: got %h want 0000", Read_data); end
    endtask

    task automatic test_write_read();
        Clear_stats = 1'b1;
        idle();
        tick();
        Clear_stats = 1'b0;
        drive(1'b0, 18'h00010, 16'hBEEF);
        tick();
        drive(1'b1, 18'h00010, 16'h0000);
        tick();
        idle();
        total++; if (Write_count !== 4'd1 || Read_count !== 4'd1) begin
            bad++; $display("FAIL wr_rd_counts: got wr=%0d rd=%0d want 1/1", Write_count, Read_count); end
        tick();
        total++; if (Read_data !== 16'hBEEF) begin bad++; $display("FAIL wr_rd_data: got %h want beef", Read_data); end
    endtask

    task automatic test_fault();
        Fault_enable  = 1'b1;
        Fault_address = 18'h00005;
        Fault_bit     = 4'd3;
        Fault_value   = 1'b0;
        wr_then_rd(18'h00005, 16'hFFFF, 18'h00005);
        total++; if (Read_data !== 16'hFFF7) begin bad++; $display("FAIL fault_hit: got %h want fff7", Read_data); end
        rd(18'h01005);
        total++; if (Read_data !== 16'hFFFF) begin bad++; $display("FAIL fault_alias: got %h want ffff", Read_data); end
        Fault_address = 18'h00007;
        Fault_bit     = 4'd0;
        Fault_value   = 1'b1;
        rd(18'h00007);
        total++; if (Read_data !== 16'h0001) begin bad++; $display("FAIL fault_sa1: got %h want 0001", Read_data); end
        Fault_enable = 1'b0;
        rd(18'h00005);
        total++; if (Read_data !== 16'hFFFF) begin bad++; $display("FAIL fault_off: got %h want ffff", Read_data); end
    endtask

    task automatic test_alias();
        wr_then_rd(18'h01002, 16'h1234, 18'h00002);
        total++; if (Read_data !== 16'h1234) begin bad++; $display("FAIL alias_low: got %h want 1234", Read_data); end
        wr_then_rd(18'h3FFFF, 16'hFFFF, 18'h00FFF);
        total++; if (Read_data !== 16'hFFFF) begin bad++; $display("FAIL alias_top: got %h want ffff", Read_data); end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 18'h00040, 16'h1111);
        tick();
        drive(1'b0, 18'h00040, 16'h2222);
        tick();
        wr_then_rd(18'h00041, 16'h3333, 18'h00040);
        total++; if (Read_data !== 16'h2222) begin bad++; $display("FAIL b2b_write: got %h want 2222", Read_data); end
        drive(1'b1, 18'h00010, 16'h0000);
        tick();
        drive(1'b1, 18'h00040, 16'h0000);
        tick();
        idle();
        total++; if (Read_data !== 16'hBEEF) begin bad++; $display("FAIL b2b_read0: got %h want beef", Read_data); end
        tick();
        total++; if (Read_data !== 16'h2222) begin bad++; $display("FAIL b2b_read1: got %h want 2222", Read_data); end
        rd(18'h00041);
        total++; if (Read_data !== 16'h3333) begin bad++; $display("FAIL b2b_neighbor: got %h want 3333", Read_data); end
    endtask

    task automatic test_clear();
        Clear_stats = 1'b1;
        drive(1'b0, 18'h00050, 16'h5555);
        tick();
        Clear_stats = 1'b0;
        drive(1'b0, 18'h00051, 16'h6666);
        total++; if (Write_count !== 4'd0 || Read_count !== 4'd0) begin
            bad++; $display("FAIL clear_prio: got wr=%0d rd=%0d want 0/0", Write_count, Read_count); end
        tick();
        idle();
        total++; if (Write_count !== 4'd1) begin bad++; $display("FAIL clear_resume: got %0d want 1", Write_count); end
        rd(18'h00050);
        total++; if (Read_data !== 16'h5555) begin bad++; $display("FAIL clear_data: got %h want 5555", Read_data); end
    endtask

    task automatic test_saturation();
        Clear_stats = 1'b1;
        idle();
        tick();
        Clear_stats = 1'b0;
        repeat (20) tick();
        total++; if (Read_count !== 4'd15) begin bad++; $display("FAIL sat_read: got %0d want 15", Read_count); end
        total++; if (Write_count !== 4'd0) begin bad++; $display("FAIL sat_write: got %0d want 0", Write_count); end
    endtask

    task automatic test_reset_mid_read();
        int n;
        drive(1'b1, 18'h00010, 16'h0000);
        repeat (3) tick();
        total++; if (Read_data !== 16'hBEEF) begin bad++; $display("FAIL mid_pre: got %h want beef", Read_data); end
        Reset = 1'b1;
        #1;
        total++; if (Read_data !== 16'h0000 || Ready !== 1'b0) begin
            bad++; $display("FAIL mid_rst: got data=%h ready=%b want 0000/0", Read_data, Ready); end
        total++; if (Read_count !== 4'd0 || Write_count !== 4'd0) begin
            bad++; $display("FAIL mid_cnt: got rd=%0d wr=%0d want 0/0", Read_count, Write_count); end
        idle();
        tick();
        Reset = 1'b0;
        wait_ready(n);
        total++; if (n !== 4096) begin bad++; $display("FAIL mid_init: got %0d want 4096", n); end
        rd(18'h00010);
        total++; if (Read_data !== 16'h0000) begin bad++; $display("FAIL mid_reinit: got %h want 0000", Read_data); end
    endtask

    task automatic test_init_drop();
        int n;
        logic [17:0] a;
        drive(1'b0, 18'h00020, 16'hAAAA);
        tick();
        drive(1'b0, 18'h00024, 16'hAAAA);
        tick();
        idle();
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a = 18'h00020 + 18'(i);
            drive(1'b0, a, 16'hAAAA);
            tick();
        end
        idle();
        wait_ready(n);
        total++; if (n !== 4091) begin bad++; $display("FAIL drop_init: got %0d want 4091", n); end
        total++; if (Dropped_count !== 4'd5) begin bad++; $display("FAIL drop_count: got %0d want 5", Dropped_count); end
        total++; if (Write_count !== 4'd0 || Read_count !== 4'd0) begin
            bad++; $display("FAIL drop_other: got wr=%0d rd=%0d want 0/0", Write_count, Read_count); end
        rd(18'h00020);
        total++; if (Read_data !== 16'h0000) begin bad++; $display("FAIL drop_mem0: got %h want 0000", Read_data); end
        rd(18'h00024);
        total++; if (Read_data !== 16'h0000) begin bad++; $display("FAIL drop_mem4: got %h want 0000", Read_data); end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        Reset         = 1'b1;
        We_n          = 1'b1;
        Address       = 18'h00000;
        Write_data    = 16'h0000;
        Fault_enable  = 1'b0;
        Fault_address = 18'h00000;
        Fault_bit     = 4'd0;
        Fault_value   = 1'b0;
        Clear_stats   = 1'b0;
        test_reset();
        test_write_read();
        test_fault();
        test_alias();
        test_back_to_back();
        test_clear();
        test_saturation();
        test_reset_mid_read();
        test_init_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sram_bist_responder
`default_nettype wire
